// File: rtl/r5fp_idiv_arb.sv
// rtl/r5fp_idiv_arb.sv - round-robin arbiter sharing one iterative divider between two requesters
module r5fp_idiv_arb #(
  parameter int ExtWidth = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                r0_strobe,
  input  logic [ExtWidth-1:0] r0_N,
  input  logic [ExtWidth-1:0] r0_D,
  output logic                r0_ready,
  output logic                r0_done,
  output logic [ExtWidth-1:0] r0_Quo,
  output logic [ExtWidth-1:0] r0_Rem,
  output logic                r0_err,
  input  logic                r1_strobe,
  input  logic [ExtWidth-1:0] r1_N,
  input  logic [ExtWidth-1:0] r1_D,
  output logic                r1_ready,
  output logic                r1_done,
  output logic [ExtWidth-1:0] r1_Quo,
  output logic [ExtWidth-1:0] r1_Rem,
  output logic                r1_err,
  output logic [ExtWidth-1:0] idiv_N,
  output logic [ExtWidth-1:0] idiv_D,
  output logic                idiv_strobe,
  input  logic [ExtWidth-1:0] idiv_Quo,
  input  logic [ExtWidth-1:0] idiv_Rem,
  input  logic                idiv_done,
  input  logic                idiv_ready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [1:0]          pend_v;
  logic [ExtWidth-1:0] pend_n [2];
  logic [ExtWidth-1:0] pend_d [2];
  logic [ExtWidth-1:0] quo_q  [2];
  logic [ExtWidth-1:0] rem_q  [2];
  logic [1:0]          done_q, err_q;
  logic                rr, owner;
  logic                grant, retire, win;
  logic [1:0]          strobe_in, ready, accept, clr;

  assign strobe_in = {r1_strobe, r0_strobe};
  // A side is blocked while its buffer is full or while the divider is working for it.
  assign ready  = ~pend_v & ~({owner, ~owner} & {2{state == BUSY}});
  assign accept = strobe_in & ready;
  assign clr    = {2{grant}} & {win, ~win};

  assign r0_ready = ready[0];
  assign r1_ready = ready[1];
  assign r0_done  = done_q[0];
  assign r1_done  = done_q[1];
  assign r0_err   = err_q[0];
  assign r1_err   = err_q[1];
  assign r0_Quo   = quo_q[0];
  assign r1_Quo   = quo_q[1];
  assign r0_Rem   = rem_q[0];
  assign r1_Rem   = rem_q[1];

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    retire    = 1'b0;
    win       = (pend_v == 2'b11) ? rr : pend_v[1];
    case (state)
      IDLE: if ((|pend_v) && idiv_ready) begin
        grant     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (idiv_done) begin
        retire    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v      <= '0;
      pend_n[0]   <= '0;
      pend_n[1]   <= '0;
      pend_d[0]   <= '0;
      pend_d[1]   <= '0;
      rr          <= 1'b0;
      owner       <= 1'b0;
      idiv_strobe <= 1'b0;
      idiv_N      <= '0;
      idiv_D      <= '0;
      done_q      <= '0;
      err_q       <= '0;
      quo_q[0]    <= '0;
      quo_q[1]    <= '0;
      rem_q[0]    <= '0;
      rem_q[1]    <= '0;
    end else begin
      pend_v <= (pend_v & ~clr) | accept;
      err_q  <= err_q | (strobe_in & ~ready);
      if (accept[0]) begin
        pend_n[0] <= r0_N;
        pend_d[0] <= r0_D;
      end
      if (accept[1]) begin
        pend_n[1] <= r1_N;
        pend_d[1] <= r1_D;
      end
      idiv_strobe <= grant;
      if (grant) begin
        idiv_N <= pend_n[win];
        idiv_D <= pend_d[win];
        owner  <= win;
        rr     <= ~win;
      end
      // Results arriving outside BUSY never set retire, so stale divider output is dropped.
      done_q <= {retire & owner, retire & ~owner};
      if (retire) begin
        quo_q[owner] <= idiv_Quo;
        rem_q[owner] <= idiv_Rem;
      end
    end
  end

endmodule

// File: tb/tb_r5fp_idiv_arb.sv
// tb/tb_r5fp_idiv_arb.sv - self-checking bench for r5fp_idiv_arb with a latency-programmable divider model
module tb_r5fp_idiv_arb;
  localparam int W = 26;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         r0_strobe, r1_strobe;
  logic [W-1:0] r0_N, r0_D, r1_N, r1_D;
  logic         r0_ready, r1_ready, r0_done, r1_done, r0_err, r1_err;
  logic [W-1:0] r0_Quo, r0_Rem, r1_Quo, r1_Rem;
  logic [W-1:0] idiv_N, idiv_D, idiv_Quo, idiv_Rem;
  logic         idiv_strobe, idiv_done, idiv_ready;

  r5fp_idiv_arb #(.ExtWidth(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_strobe(r0_strobe), .r0_N(r0_N), .r0_D(r0_D), .r0_ready(r0_ready),
    .r0_done(r0_done), .r0_Quo(r0_Quo), .r0_Rem(r0_Rem), .r0_err(r0_err),
    .r1_strobe(r1_strobe), .r1_N(r1_N), .r1_D(r1_D), .r1_ready(r1_ready),
    .r1_done(r1_done), .r1_Quo(r1_Quo), .r1_Rem(r1_Rem), .r1_err(r1_err),
    .idiv_N(idiv_N), .idiv_D(idiv_D), .idiv_strobe(idiv_strobe),
    .idiv_Quo(idiv_Quo), .idiv_Rem(idiv_Rem), .idiv_done(idiv_done), .idiv_ready(idiv_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    int           side;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } ev_t;

  ev_t req_log[$];
  ev_t str_log[$];
  ev_t done_log[$];
  int  div_done_log[$];
  int  exp_idx[$];

  int           cyc = 0;
  int           viol = 0;
  logic         prev_str = 1'b0;
  int           passed = 0, total = 0;
  int           lat_cfg = 13;
  int           dcnt = 0;
  logic [W-1:0] dn = '0, dd = '1;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: result appears lat cycles after the start pulse; outputs are junk otherwise.
  always @(negedge clk) begin
    idiv_done <= 1'b0;
    idiv_Quo  <= W'($urandom);
    idiv_Rem  <= W'($urandom);
    if (dcnt == 1) begin
      idiv_done <= 1'b1;
      idiv_Quo  <= dn / dd;
      idiv_Rem  <= dn % dd;
      div_done_log.push_back(cyc);
    end
    if (dcnt > 0) dcnt <= dcnt - 1;
    if (idiv_strobe) begin
      dn   <= idiv_N;
      dd   <= idiv_D;
      dcnt <= (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 8));
    end
  end

  always @(negedge clk) begin
    if (idiv_strobe) begin
      str_log.push_back('{cyc, -1, idiv_N, idiv_D});
      if (prev_str) viol <= viol + 1;
    end
    prev_str <= idiv_strobe;
    if (r0_done) done_log.push_back('{cyc, 0, r0_Quo, r0_Rem});
    if (r1_done) done_log.push_back('{cyc, 1, r1_Quo, r1_Rem});
  end

  function automatic logic [W-1:0] rnd_n();
    return W'($urandom);
  endfunction

  function automatic logic [W-1:0] rnd_d();
    logic [W-1:0] v;
    v = W'($urandom) >> $urandom_range(0, W - 1);
    return v | W'(1);
  endfunction

  // Reference arbitration: for each observed start, which logged request should it carry.
  function automatic void build_expect();
    int q0[$];
    int q1[$];
    int n0, n1, rr, w;
    bit c0, c1;
    n0 = 0; n1 = 0; rr = 0;
    exp_idx.delete();
    foreach (req_log[i]) begin
      if (req_log[i].side == 0) q0.push_back(i);
      else q1.push_back(i);
    end
    foreach (str_log[k]) begin
      c0 = (n0 < q0.size()) && (req_log[q0[n0]].cyc <= str_log[k].cyc - 2);
      c1 = (n1 < q1.size()) && (req_log[q1[n1]].cyc <= str_log[k].cyc - 2);
      w  = (c0 && c1) ? rr : (c0 ? 0 : (c1 ? 1 : -1));
      if (w == 0) begin
        exp_idx.push_back(q0[n0]); n0++; rr = 1;
      end else if (w == 1) begin
        exp_idx.push_back(q1[n1]); n1++; rr = 0;
      end else begin
        exp_idx.push_back(-1);
      end
    end
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    r0_strobe = 1'b0;
    r1_strobe = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic issue(input int side, input logic [W-1:0] n, input logic [W-1:0] d);
    if (side == 0) begin
      r0_strobe = 1'b1; r0_N = n; r0_D = d;
    end else begin
      r1_strobe = 1'b1; r1_N = n; r1_D = d;
    end
    req_log.push_back('{cyc, side, n, d});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(2);
    req_log.delete(); str_log.delete(); done_log.delete(); div_done_log.delete();
  endtask

  task automatic test_reset();
    run(2);
    total++;
    if ({r0_ready, r1_ready} !== 2'b11) $display("FAIL reset_ready got %b want 11", {r0_ready, r1_ready});
    else passed++;
    total++;
    if ({idiv_strobe, r0_done, r1_done, r0_err, r1_err} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {idiv_strobe, r0_done, r1_done, r0_err, r1_err});
    else passed++;
    total++;
    if ({idiv_N, idiv_D, r0_Quo, r0_Rem, r1_Quo, r1_Rem} !== '0)
      $display("FAIL reset_data got %h want 0", {idiv_N, idiv_D, r0_Quo, r0_Rem, r1_Quo, r1_Rem});
    else passed++;
    reset_n = 1'b1;
    run(3);
    total++;
    if ({r0_ready, r1_ready, idiv_strobe} !== 3'b110) $display("FAIL post_reset_idle got %b want 110", {r0_ready, r1_ready, idiv_strobe});
    else passed++;
  endtask

  task automatic test_single();
    int t;
    do_reset();
    lat_cfg = 13;
    t = cyc;
    issue(0, 26'h0800000, 26'h0400000);
    next_cycle();
    total++;
    if (r0_ready !== 1'b0) $display("FAIL single_ready_low got %b want 0", r0_ready);
    else passed++;
    run(22);
    total++;
    if (str_log.size() != 1 || str_log[0].cyc != t + 2 || str_log[0].a !== 26'h0800000 || str_log[0].b !== 26'h0400000)
      $display("FAIL single_strobe got n=%0d cyc=%0d want n=1 cyc=%0d", str_log.size(), (str_log.size() > 0) ? str_log[0].cyc : -1, t + 2);
    else passed++;
    total++;
    if (done_log.size() != 1 || done_log[0].side != 0 || done_log[0].cyc != t + 16 || done_log[0].a !== 26'd2 || done_log[0].b !== 26'd0)
      $display("FAIL single_done got n=%0d cyc=%0d want n=1 side0 cyc=%0d q=2 r=0", done_log.size(), (done_log.size() > 0) ? done_log[0].cyc : -1, t + 16);
    else passed++;
    total++;
    if (r0_Quo !== 26'd2 || r0_Rem !== 26'd0 || r0_ready !== 1'b1) $display("FAIL single_hold got q=%h r=%h rdy=%b want 2 0 1", r0_Quo, r0_Rem, r0_ready);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int t;
    logic [W-1:0] n0, d0, n1, d1;
    do_reset();
    lat_cfg = 5;
    n0 = rnd_n(); d0 = rnd_d(); n1 = rnd_n(); d1 = rnd_d();
    t = cyc;
    issue(0, n0, d0);
    issue(1, n1, d1);
    run(20);
    total++;
    if (str_log.size() != 2) $display("FAIL simul_count got %0d want 2", str_log.size());
    else passed++;
    if (str_log.size() == 2 && done_log.size() == 2) begin
      total++;
      if (str_log[0].cyc != t + 2 || str_log[0].a !== n0 || str_log[0].b !== d0)
        $display("FAIL simul_first got cyc=%0d n=%h want cyc=%0d n=%h", str_log[0].cyc, str_log[0].a, t + 2, n0);
      else passed++;
      total++;
      if (str_log[1].cyc != t + 9 || str_log[1].a !== n1 || str_log[1].b !== d1)
        $display("FAIL simul_second got cyc=%0d n=%h want cyc=%0d n=%h", str_log[1].cyc, str_log[1].a, t + 9, n1);
      else passed++;
      total++;
      if (done_log[0].side != 0 || done_log[0].a !== n0 / d0 || done_log[0].b !== n0 % d0 ||
          done_log[1].side != 1 || done_log[1].a !== n1 / d1 || done_log[1].b !== n1 % d1)
        $display("FAIL simul_route got sides %0d,%0d q %h,%h want 0,1 q %h,%h",
                 done_log[0].side, done_log[1].side, done_log[0].a, done_log[1].a, n0 / d0, n1 / d1);
      else passed++;
    end else begin
      total++;
      $display("FAIL simul_done_count got %0d want 2", done_log.size());
    end
  endtask

  task automatic test_fairness();
    int sent0, sent1, nd;
    do_reset();
    lat_cfg = 0;
    issue(0, rnd_n(), rnd_d());
    issue(1, rnd_n(), rnd_d());
    sent0 = 1; sent1 = 1;
    for (int i = 0; i < 400 && done_log.size() < 8; i++) begin
      next_cycle();
      if (r0_done && sent0 < 4) begin issue(0, rnd_n(), rnd_d()); sent0++; end
      if (r1_done && sent1 < 4) begin issue(1, rnd_n(), rnd_d()); sent1++; end
    end
    run(5);
    total++;
    if (done_log.size() != 8) $display("FAIL fair_count got %0d want 8", done_log.size());
    else passed++;
    nd = (done_log.size() < 8) ? done_log.size() : 8;
    for (int k = 0; k < nd; k++) begin
      total++;
      if (done_log[k].side != k % 2) $display("FAIL fair_order op %0d got side %0d want %0d", k, done_log[k].side, k % 2);
      else passed++;
    end
    for (int k = 0; k + 1 < str_log.size() && k < div_done_log.size(); k++) begin
      total++;
      if (str_log[k + 1].cyc != div_done_log[k] + 2)
        $display("FAIL fair_gap op %0d got cyc %0d want %0d", k, str_log[k + 1].cyc, div_done_log[k] + 2);
      else passed++;
    end
  endtask

  task automatic test_error();
    int t;
    logic [W-1:0] na, da;
    do_reset();
    lat_cfg = 6;
    na = rnd_n(); da = rnd_d();
    t = cyc;
    issue(1, na, da);
    next_cycle();
    r1_strobe = 1'b1; r1_N = ~na; r1_D = da ^ 26'h1555555;
    next_cycle();
    total++;
    if ({r1_err, r0_err} !== 2'b10) $display("FAIL err_flag got r1=%b r0=%b want 1 0", r1_err, r0_err);
    else passed++;
    run(15);
    total++;
    if (str_log.size() != 1 || str_log[0].a !== na || str_log[0].b !== da)
      $display("FAIL err_operands got n=%0d N=%h want 1 N=%h", str_log.size(), (str_log.size() > 0) ? str_log[0].a : '0, na);
    else passed++;
    total++;
    if (done_log.size() != 1 || done_log[0].side != 1 || done_log[0].a !== na / da || done_log[0].b !== na % da || done_log[0].cyc != t + 9)
      $display("FAIL err_single_done got n=%0d want 1 side1 q=%h", done_log.size(), na / da);
    else passed++;
    total++;
    if (r1_err !== 1'b1) $display("FAIL err_sticky got %b want 1", r1_err);
    else passed++;
  endtask

  task automatic test_stall();
    int u;
    logic [W-1:0] n, d;
    do_reset();
    lat_cfg = 5;
    idiv_ready = 1'b0;
    n = rnd_n(); d = rnd_d();
    issue(0, n, d);
    run(20);
    total++;
    if (str_log.size() != 0 || r0_ready !== 1'b0) $display("FAIL stall_hold got strobes=%0d rdy=%b want 0 0", str_log.size(), r0_ready);
    else passed++;
    u = cyc;
    idiv_ready = 1'b1;
    run(12);
    total++;
    if (str_log.size() != 1 || str_log[0].cyc != u + 1)
      $display("FAIL stall_release got n=%0d cyc=%0d want 1 cyc=%0d", str_log.size(), (str_log.size() > 0) ? str_log[0].cyc : -1, u + 1);
    else passed++;
    total++;
    if (done_log.size() != 1 || done_log[0].a !== n / d || done_log[0].b !== n % d)
      $display("FAIL stall_result got n=%0d want 1 q=%h", done_log.size(), n / d);
    else passed++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    lat_cfg = 10;
    issue(0, rnd_n(), rnd_d());
    run(4);
    reset_n = 1'b0;
    #1;
    total++;
    if ({r0_ready, r1_ready, idiv_strobe} !== 3'b110 || idiv_N !== '0 || idiv_D !== '0)
      $display("FAIL midop_async got rdy=%b%b stb=%b N=%h want 11 0 0", r0_ready, r1_ready, idiv_strobe, idiv_N);
    else passed++;
    run(2);
    reset_n = 1'b1;
    run(15);
    total++;
    if (done_log.size() != 0) $display("FAIL midop_no_done got %0d want 0", done_log.size());
    else passed++;
    total++;
    if ({r0_Quo, r0_Rem, r1_Quo, r1_Rem, idiv_N, idiv_D} !== '0 || {r0_err, r1_err, idiv_strobe} !== 3'b0 || {r0_ready, r1_ready} !== 2'b11)
      $display("FAIL midop_outputs got q0=%h q1=%h rdy=%b%b want 0 0 11", r0_Quo, r1_Quo, r0_ready, r1_ready);
    else passed++;
  endtask

  task automatic test_random();
    int e;
    logic [W-1:0] eq, er;
    do_reset();
    lat_cfg = 0;
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      idiv_ready = ($urandom_range(0, 3) != 0);
      if (r0_ready && $urandom_range(0, 2) == 0) issue(0, rnd_n(), rnd_d());
      if (r1_ready && $urandom_range(0, 2) == 0) issue(1, rnd_n(), rnd_d());
    end
    idiv_ready = 1'b1;
    run(30);
    build_expect();
    total++;
    if (str_log.size() != req_log.size() || done_log.size() != req_log.size())
      $display("FAIL rand_counts got strobes=%0d dones=%0d want %0d", str_log.size(), done_log.size(), req_log.size());
    else passed++;
    foreach (str_log[k]) begin
      e = exp_idx[k];
      total++;
      if (e < 0) begin
        $display("FAIL rand_grant op %0d got start at cyc %0d want none", k, str_log[k].cyc);
      end else if (str_log[k].a !== req_log[e].a || str_log[k].b !== req_log[e].b) begin
        $display("FAIL rand_operands op %0d got %h/%h want %h/%h", k, str_log[k].a, str_log[k].b, req_log[e].a, req_log[e].b);
      end else passed++;
      if (e >= 0 && k < done_log.size() && k < div_done_log.size()) begin
        eq = req_log[e].a / req_log[e].b;
        er = req_log[e].a % req_log[e].b;
        total++;
        if (done_log[k].side != req_log[e].side || done_log[k].a !== eq || done_log[k].b !== er || done_log[k].cyc != div_done_log[k] + 1)
          $display("FAIL rand_result op %0d got side %0d q=%h r=%h cyc=%0d want side %0d q=%h r=%h cyc=%0d",
                   k, done_log[k].side, done_log[k].a, done_log[k].b, done_log[k].cyc, req_log[e].side, eq, er, div_done_log[k] + 1);
        else passed++;
      end
    end
  endtask

  task automatic test_strobe_spacing();
    total++;
    if (viol != 0) $display("FAIL strobe_consecutive got %0d want 0", viol);
    else passed++;
  endtask

  initial begin
    reset_n    = 1'b0;
    r0_strobe  = 1'b0; r1_strobe = 1'b0;
    r0_N = '0; r0_D = '0; r1_N = '0; r1_D = '0;
    idiv_ready = 1'b1;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_error();
    test_stall();
    test_reset_midop();
    test_random();
    test_strobe_spacing();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
